// File: rtl/blake2_pkg.sv
// -----------------------------------------------------------------------------
// blake2_pkg
// Shared definitions for the BLAKE2b message schedule:
//   NUM_ROUNDS_DEF - default number of rounds per block (BLAKE2b = 12)
//   state_t        - sequencer FSM encoding
//   SIGMA          - 10x16 message permutation table. Each row is one 64-bit
//                    literal whose most-significant nibble is element 0.
// -----------------------------------------------------------------------------
package blake2_pkg;

   localparam int NUM_ROUNDS_DEF = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef logic [0:15][3:0] sigma_row_t;

   localparam logic [0:9][0:15][3:0] SIGMA = {
      64'h0123456789ABCDEF,
      64'hEA489FD61C02B753,
      64'hB8C052FDAE367194,
      64'h7931DCBE265A40F8,
      64'h905724AFE1BC683D,
      64'h2C6A0B834D75FE19,
      64'hC51FED4A0763928B,
      64'hDB7EC13950F4862A,
      64'h6FE9B308C2D741A5,
      64'hA2847615FB9E3CD0
   };

endpackage

// File: rtl/blake2_sigma.sv
// -----------------------------------------------------------------------------
// blake2_sigma
// Combinational sigma row lookup.
//   round - current round index (0..15 accepted)
//   idx   - the 16 four-bit word indices of sigma row (round mod 10)
// -----------------------------------------------------------------------------
module blake2_sigma
   import blake2_pkg::*;
(
   input  logic [3:0]       round,
   output sigma_row_t       idx
);

   logic [3:0] row;

   // A round index never exceeds 15, so one conditional subtract is mod 10.
   always_comb begin
      row = (round >= 4'd10) ? (round - 4'd10) : round;
      idx = SIGMA[row];
   end

endmodule

// File: rtl/blake2_m_sched.sv
// -----------------------------------------------------------------------------
// blake2_m_sched
// Holds one 1024-bit message block and steps through NUM_ROUNDS rounds of
// column/diagonal G steps, presenting the permuted message words for the four
// parallel G instances.
//   clk, reset_n        - clock, synchronous active-low reset
//   load, block         - capture a block (honoured only when idle)
//   start               - begin sequencing the held block (idle only)
//   next                - G stage accepts the current step
//   ready               - idle, start accepted
//   g_valid             - round/mode/words valid for the G stage
//   round, mode         - current round and step (0 column, 1 diagonal)
//   gN_m0, gN_m1        - message words for G instance N
//   done                - one-cycle pulse after the final step is accepted
// -----------------------------------------------------------------------------
module blake2_m_sched
   import blake2_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [1023:0] block,
   input  logic          start,
   input  logic          next,
   output logic          ready,
   output logic          g_valid,
   output logic [3:0]    round,
   output logic          mode,
   output logic [63:0]   g0_m0,
   output logic [63:0]   g0_m1,
   output logic [63:0]   g1_m0,
   output logic [63:0]   g1_m1,
   output logic [63:0]   g2_m0,
   output logic [63:0]   g2_m1,
   output logic [63:0]   g3_m0,
   output logic [63:0]   g3_m1,
   output logic          done
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

   state_t        state_q, state_d;
   logic [3:0]    round_q, round_d;
   logic          mode_q, mode_d;
   logic [1023:0] blk_q;
   sigma_row_t    idx;
   logic [63:0]   word [16];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         round_q <= 4'd0;
         mode_q  <= 1'b0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         mode_q  <= mode_d;
         // Block is frozen outside IDLE so the words cannot change mid-block.
         if (state_q == ST_IDLE && load)
            blk_q <= block;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      mode_d  = mode_q;
      ready   = 1'b0;
      g_valid = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_d = ST_RUN;
               round_d = 4'd0;
               mode_d  = 1'b0;
            end
         end
         ST_RUN: begin
            g_valid = 1'b1;
            if (next) begin
               if (!mode_q) begin
                  mode_d = 1'b1;
               end else if (round_q == LAST_ROUND) begin
                  state_d = ST_DONE;
                  round_d = 4'd0;
                  mode_d  = 1'b0;
               end else begin
                  mode_d  = 1'b0;
                  round_d = round_q + 4'd1;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   blake2_sigma u_sigma (
      .round (round_q),
      .idx   (idx)
   );

   always_comb begin
      for (int i = 0; i < 16; i++)
         word[i] = blk_q[1023 - 64*i -: 64];
   end

   assign round = round_q;
   assign mode  = mode_q;

   // Diagonal steps use sigma entries 8..15, column steps 0..7.
   assign g0_m0 = word[idx[{mode_q, 3'd0}]];
   assign g0_m1 = word[idx[{mode_q, 3'd1}]];
   assign g1_m0 = word[idx[{mode_q, 3'd2}]];
   assign g1_m1 = word[idx[{mode_q, 3'd3}]];
   assign g2_m0 = word[idx[{mode_q, 3'd4}]];
   assign g2_m1 = word[idx[{mode_q, 3'd5}]];
   assign g3_m0 = word[idx[{mode_q, 3'd6}]];
   assign g3_m1 = word[idx[{mode_q, 3'd7}]];

endmodule

// File: doc/blake2_m_sched.md
BLAKE2_M_SCHED -- requirements
Module: blake2_m_sched

Interface
REQ-001 Parameter NUM_ROUNDS, default 12, number of rounds sequenced per block (BLAKE2b).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  capture block into message register.
REQ-005 block  input  1024  message block; word i = block[1023-64*i -: 64], i=0..15, byte order already fixed upstream.
REQ-006 start  input  1  begin round sequencing of the held block.
REQ-007 next  input  1  downstream G stage accepts current words (advance).
REQ-008 ready  output  1  idle; start accepted.
REQ-009 g_valid  output  1  round, mode, gN_m0/gN_m1 valid for the G stage.
REQ-010 round  output  4  current round index, 0..NUM_ROUNDS-1.
REQ-011 mode  output  1  0 = column step, 1 = diagonal step.
REQ-012 g0_m0, g0_m1, g1_m0, g1_m1, g2_m0, g2_m1, g3_m0, g3_m1  output  64 each  message words for the four parallel G instances.
REQ-013 done  output  1  one-cycle pulse: final step accepted.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: ready=1, g_valid=0; start -> RUN with round=0, mode=0.
REQ-016 RUN: g_valid=1; on next=1, mode 0->1 (round held), or mode 1->0 with round+1.
REQ-017 RUN: next=1 at round=NUM_ROUNDS-1, mode=1 -> DONE; next=0 holds all outputs stable (stall, no limit).
REQ-018 DONE: done=1, ready=0, g_valid=0 for exactly one cycle, then IDLE.
REQ-019 Latency: start sampled at edge t -> g_valid=1 with round 0 column words from cycle t+1.
REQ-020 Sigma row s = round mod 10 (rounds 10, 11 reuse rows 0, 1).
REQ-021 Column (mode 0): gk_m0 = word[sigma[s][2k]], gk_m1 = word[sigma[s][2k+1]], k=0..3.
REQ-022 Diagonal (mode 1): gk_m0 = word[sigma[s][8+2k]], gk_m1 = word[sigma[s][9+2k]].
REQ-023 Word outputs are combinational from registered block, round, mode; no arithmetic on words.
REQ-024 load honoured only in IDLE; ignored in RUN and DONE (block stable during sequencing).
REQ-025 load and start in same IDLE cycle: new block captured, sequencing uses it.
REQ-026 start outside IDLE ignored; next outside RUN ignored.

Reset
REQ-027 reset_n=0 at an edge, in any state including mid-RUN: state=IDLE, round=0, mode=0, block register=0, g_valid=0, done=0; ready=1 from the first cycle after release.
REQ-028 Reset aborts sequencing; no done pulse is produced for an aborted block.

Structure
REQ-029 Package blake2_pkg holds NUM_ROUNDS default, the 10x16 sigma table, and the FSM state encodings.
REQ-030 One sub-module blake2_sigma: combinational, input round (4), output 16 four-bit indices for row round mod 10.

Verification
REQ-031 Block word i = 64'h0...0i; load+start, next=1 -> cycle t+1: round 0, mode 0, g0_m0=0, g0_m1=1, g3_m0=6, g3_m1=7; t+2 diagonal: g0_m0=8, g3_m1=15.
REQ-032 Same block, round 1 column -> g0_m0=14, g0_m1=10, g1_m0=4, g1_m1=8; round 10 words equal round 0, round 11 equal round 1.
REQ-033 next held high from t+1 -> exactly 24 g_valid cycles (t+1..t+24), done=1 at t+25 only, ready=1 at t+26.
REQ-034 next=0 for 5 cycles at round 3 mode 1 -> outputs unchanged across stall; resumes to round 4 mode 0 on next=1.
REQ-035 load of different block during RUN -> outputs keep original words; after done, load+start uses new block.
REQ-036 reset_n=0 at round 6 -> next cycle g_valid=0, round=0, mode=0, ready=1, no done pulse; a fresh start sequences normally.
